// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle control sequencer:
// opcodes, FSM states, datapath select encodings and the decoded control bundle.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_TRAP   = 3'd6;

   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_IMM   = 2'd1;
   localparam logic [1:0] PC_ALU   = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [1:0] A_RS1  = 2'd0;
   localparam logic [1:0] A_PC   = 2'd1;
   localparam logic [1:0] A_ZERO = 2'd2;

   localparam logic [1:0] B_RS2  = 2'd0;
   localparam logic [1:0] B_IMM  = 2'd1;
   localparam logic [1:0] B_FOUR = 2'd2;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [3:0] ALU_ADD = 4'b0000;

   typedef struct packed {
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic [2:0] imm_sel;
      logic [1:0] wb_sel;
      logic [1:0] wb_pc_src;
      logic       is_load;
      logic       is_store;
      logic       is_branch;
   } ctrl_t;

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational opcode/funct decode into the per-instruction control bundle.
module rv_ctrl_decode
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output ctrl_t      ctrl,
   output logic       illegal_op
);

   always_comb begin
      ctrl           = '0;
      ctrl.alu_src_a = A_RS1;
      ctrl.alu_src_b = B_IMM;
      ctrl.alu_op    = ALU_ADD;
      ctrl.imm_sel   = IMM_I;
      ctrl.wb_sel    = WB_ALU;
      ctrl.wb_pc_src = PC_PLUS4;
      illegal_op     = 1'b0;
      case (opcode)
         OP_R: begin
            ctrl.alu_src_b = B_RS2;
            ctrl.alu_op    = {funct7_5, funct3};
         end
         // funct7[5] only selects SRA vs SRL among the immediate forms
         OP_IMM:   ctrl.alu_op = {(funct3 == 3'b101) & funct7_5, funct3};
         OP_LOAD: begin
            ctrl.is_load = 1'b1;
            ctrl.wb_sel  = WB_MEM;
         end
         OP_STORE: begin
            ctrl.is_store = 1'b1;
            ctrl.imm_sel  = IMM_S;
         end
         OP_BRANCH: begin
            ctrl.is_branch = 1'b1;
            ctrl.alu_src_b = B_RS2;
            ctrl.alu_op    = {1'b1, funct3};
            ctrl.imm_sel   = IMM_B;
         end
         OP_JAL: begin
            ctrl.alu_src_a = A_PC;
            ctrl.alu_src_b = B_FOUR;
            ctrl.imm_sel   = IMM_J;
            ctrl.wb_sel    = WB_PC4;
            ctrl.wb_pc_src = PC_IMM;
         end
         OP_JALR: begin
            ctrl.wb_sel    = WB_PC4;
            ctrl.wb_pc_src = PC_ALU;
         end
         OP_LUI: begin
            ctrl.alu_src_a = A_ZERO;
            ctrl.imm_sel   = IMM_U;
         end
         OP_AUIPC: begin
            ctrl.alu_src_a = A_PC;
            ctrl.imm_sel   = IMM_U;
         end
         default:  illegal_op = 1'b1;
      endcase
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with sticky illegal-opcode
// and memory-timeout traps.
module rv_multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        take_branch,
   output logic        ir_wr,
   output logic        pc_wr,
   output logic [1:0]  pc_src,
   output logic        reg_rd,
   output logic        reg_wr,
   output logic [1:0]  wb_sel,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  alu_op,
   output logic [2:0]  imm_sel,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        busy,
   output logic        illegal,
   output logic        timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [2:0]       state_reg, state_next;
   logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next, wait_cnt_inc;
   logic             illegal_reg, illegal_next;
   logic             timeout_reg, timeout_next;
   logic             wait_expired;
   logic [2:0]       boundary_state;
   ctrl_t            ctrl;
   logic             illegal_op;
   logic             unused_instr_bits;

   assign unused_instr_bits = ^{instr[31], instr[29:15]};

   rv_ctrl_decode u_decode (
      .opcode     (instr[6:0]),
      .funct3     (instr[14:12]),
      .funct7_5   (instr[30]),
      .ctrl       (ctrl),
      .illegal_op (illegal_op)
   );

   assign wait_cnt_inc   = wait_cnt_reg + CNT_W'(1);
   assign wait_expired   = (wait_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
   assign boundary_state = stop ? S_IDLE : S_FETCH;

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      illegal_next  = illegal_reg;
      timeout_next  = timeout_reg;
      case (state_reg)
         S_IDLE:   if (start) state_next = S_FETCH;
         S_FETCH: begin
            if (mem_ready)         state_next = S_DECODE;
            else if (wait_expired) begin
               state_next   = S_TRAP;
               timeout_next = 1'b1;
            end else               wait_cnt_next = wait_cnt_inc;
         end
         S_DECODE: begin
            if (illegal_op) begin
               state_next   = S_TRAP;
               illegal_next = 1'b1;
            end else state_next = S_EXEC;
         end
         S_EXEC: begin
            if (ctrl.is_branch)                    state_next = boundary_state;
            else if (ctrl.is_load | ctrl.is_store) state_next = S_MEM;
            else                                   state_next = S_WB;
         end
         S_MEM: begin
            if (mem_ready)         state_next = ctrl.is_store ? boundary_state : S_WB;
            else if (wait_expired) begin
               state_next   = S_TRAP;
               timeout_next = 1'b1;
            end else               wait_cnt_next = wait_cnt_inc;
         end
         S_WB:     state_next = boundary_state;
         S_TRAP:   state_next = S_TRAP;
         default:  state_next = S_IDLE;
      endcase
      // Each memory wait phase gets a fresh budget
      if ((state_next == S_FETCH && state_reg != S_FETCH) ||
          (state_next == S_MEM && state_reg != S_MEM))
         wait_cnt_next = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         wait_cnt_reg <= '0;
         illegal_reg  <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         illegal_reg  <= illegal_next;
         timeout_reg  <= timeout_next;
      end
   end

   always_comb begin
      ir_wr        = 1'b0;
      pc_wr        = 1'b0;
      pc_src       = PC_PLUS4;
      reg_rd       = 1'b0;
      reg_wr       = 1'b0;
      wb_sel       = WB_ALU;
      alu_src_a    = A_RS1;
      alu_src_b    = B_RS2;
      alu_op       = ALU_ADD;
      imm_sel      = IMM_I;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      case (state_reg)
         S_FETCH: begin
            mem_req = 1'b1;
            ir_wr   = mem_ready;
         end
         S_DECODE: reg_rd = 1'b1;
         S_EXEC: begin
            alu_src_a = ctrl.alu_src_a;
            alu_src_b = ctrl.alu_src_b;
            alu_op    = ctrl.alu_op;
            imm_sel   = ctrl.imm_sel;
            if (ctrl.is_branch) begin
               pc_wr  = 1'b1;
               pc_src = take_branch ? PC_IMM : PC_PLUS4;
            end
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = ctrl.is_store;
            pc_wr        = ctrl.is_store & mem_ready;
         end
         S_WB: begin
            // x0 is not write-protected in the register file
            reg_wr  = |instr[11:7];
            wb_sel  = ctrl.wb_sel;
            pc_wr   = 1'b1;
            pc_src  = ctrl.wb_pc_src;
            imm_sel = ctrl.imm_sel;
         end
         default: ;
      endcase
   end

   assign busy    = (state_reg != S_IDLE) && (state_reg != S_TRAP);
   assign illegal = illegal_reg;
   assign timeout = timeout_reg;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized instruction-level bench for rv_multicycle_ctrl against a phase model.
module tb_rv_multicycle_ctrl;

   localparam int CL_R = 0, CL_I = 1, CL_LD = 2, CL_ST = 3, CL_BR = 4;
   localparam int CL_JAL = 5, CL_JALR = 6, CL_LUI = 7, CL_AUIPC = 8, CL_ILL = 9;

   logic        clk = 1'b0;
   logic        rst_n, start, stop, mem_ready, take_branch;
   logic [31:0] instr;
   logic        ir_wr, pc_wr, reg_rd, reg_wr, mem_req, mem_we, mem_addr_sel;
   logic        busy, illegal, timeout;
   logic [1:0]  pc_src, wb_sel, alu_src_a, alu_src_b;
   logic [3:0]  alu_op;
   logic [2:0]  imm_sel;

   int n_checks = 0;
   int n_errors = 0;

   rv_multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .instr(instr),
      .mem_ready(mem_ready), .take_branch(take_branch), .ir_wr(ir_wr),
      .pc_wr(pc_wr), .pc_src(pc_src), .reg_rd(reg_rd), .reg_wr(reg_wr),
      .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .imm_sel(imm_sel), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .busy(busy), .illegal(illegal), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   // Every control output low; sticky flags compared separately.
   task automatic check_quiet(input string tag, input logic exp_ill, input logic exp_to);
      check(tag, 32'({ir_wr, pc_wr, pc_src, reg_rd, reg_wr, wb_sel, alu_src_a, alu_src_b,
                      alu_op, imm_sel, mem_req, mem_we, mem_addr_sel, busy}), 32'd0);
      check({tag, "_flags"}, 32'({illegal, timeout}), 32'({exp_ill, exp_to}));
   endtask

   function automatic int cls_of(input logic [31:0] i);
      case (i[6:0])
         7'b0110011: return CL_R;
         7'b0010011: return CL_I;
         7'b0000011: return CL_LD;
         7'b0100011: return CL_ST;
         7'b1100011: return CL_BR;
         7'b1101111: return CL_JAL;
         7'b1100111: return CL_JALR;
         7'b0110111: return CL_LUI;
         7'b0010111: return CL_AUIPC;
         default:    return CL_ILL;
      endcase
   endfunction

   // Expected {alu_src_a, alu_src_b, alu_op, imm_sel} during EXEC.
   function automatic logic [10:0] exp_exec(input logic [31:0] i);
      logic [2:0] f3;
      logic       b30;
      f3  = i[14:12];
      b30 = i[30];
      case (cls_of(i))
         CL_R:     return {2'd0, 2'd0, b30, f3, 3'd0};
         CL_I:     return {2'd0, 2'd1, (f3 == 3'd5) & b30, f3, 3'd0};
         CL_LD:    return {2'd0, 2'd1, 4'd0, 3'd0};
         CL_JALR:  return {2'd0, 2'd1, 4'd0, 3'd0};
         CL_ST:    return {2'd0, 2'd1, 4'd0, 3'd1};
         CL_BR:    return {2'd0, 2'd0, 1'b1, f3, 3'd2};
         CL_JAL:   return {2'd1, 2'd2, 4'd0, 3'd4};
         CL_LUI:   return {2'd2, 2'd1, 4'd0, 3'd3};
         CL_AUIPC: return {2'd1, 2'd1, 4'd0, 3'd3};
         default:  return 11'd0;
      endcase
   endfunction

   // Entered at a negedge with the DUT in FETCH; leaves at a negedge in FETCH
   // (or in TRAP for an illegal opcode).
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic tbr, input logic stp);
      int         c;
      logic       ld, st, br;
      logic [1:0] ex_wb_sel, ex_pc_src;
      c  = cls_of(ins);
      ld = (c == CL_LD);
      st = (c == CL_ST);
      br = (c == CL_BR);
      $display("TXN instr=%08h class=%0d fetch_wait=%0d mem_wait=%0d take_branch=%0d stop=%0d",
               ins, c, fw, mw, tbr, stp);
      for (int k = 0; k <= fw; k++) begin
         mem_ready   = (k == fw);
         instr       = (k == fw) ? ins : $urandom;
         take_branch = 1'($urandom);
         stop        = 1'($urandom);
         #1;
         check("fetch_ctl", 32'({mem_req, mem_addr_sel, mem_we, busy}), 32'(4'b1001));
         check("fetch_ir_wr", 32'(ir_wr), 32'(k == fw));
         check("fetch_quiet", 32'({pc_wr, reg_rd, reg_wr}), 32'd0);
         @(negedge clk);
      end
      mem_ready = 1'($urandom);
      stop      = 1'($urandom);
      #1;
      check("decode", 32'({reg_rd, mem_req, ir_wr, pc_wr, reg_wr, busy}), 32'(6'b100001));
      @(negedge clk);
      if (c == CL_ILL) begin
         mem_ready = 1'b0;
         #1;
         check_quiet("trap", 1'b1, 1'b0);
         return;
      end
      mem_ready   = 1'($urandom);
      take_branch = tbr;
      stop        = br ? stp : 1'($urandom);
      #1;
      check("exec_alu", 32'({alu_src_a, alu_src_b, alu_op, imm_sel}), 32'(exp_exec(ins)));
      check("exec_pc", 32'({pc_wr, pc_src}), br ? 32'({1'b1, 1'b0, tbr}) : 32'd0);
      check("exec_quiet", 32'({mem_req, reg_rd, reg_wr, ir_wr}), 32'd0);
      @(negedge clk);
      if (ld || st) begin
         for (int k = 0; k <= mw; k++) begin
            mem_ready = (k == mw);
            stop      = (st && k == mw) ? stp : 1'($urandom);
            #1;
            check("mem_ctl", 32'({mem_req, mem_addr_sel, mem_we}), 32'({2'b11, st}));
            check("mem_pc", 32'({pc_wr, pc_src}), 32'({st && k == mw, 2'b00}));
            check("mem_quiet", 32'({reg_wr, reg_rd, ir_wr, alu_op}), 32'd0);
            @(negedge clk);
         end
      end
      if (!br && !st) begin
         ex_wb_sel = ld ? 2'd1 : (c == CL_JAL || c == CL_JALR) ? 2'd2 : 2'd0;
         ex_pc_src = (c == CL_JAL) ? 2'd1 : (c == CL_JALR) ? 2'd2 : 2'd0;
         mem_ready = 1'($urandom);
         stop      = stp;
         #1;
         check("wb_reg_wr", 32'(reg_wr), 32'(ins[11:7] != 5'd0));
         check("wb_sel", 32'(wb_sel), 32'(ex_wb_sel));
         check("wb_pc", 32'({pc_wr, pc_src}), 32'({1'b1, ex_pc_src}));
         check("wb_quiet", 32'({mem_req, reg_rd, ir_wr}), 32'd0);
         @(negedge clk);
      end
      mem_ready = 1'b0;
      stop      = 1'b0;
      #1;
      check("boundary", 32'({busy, mem_req, mem_addr_sel}), stp ? 32'd0 : 32'(3'b110));
      if (stp) begin
         check_quiet("idle_after_stop", 1'b0, 1'b0);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   logic [6:0]  ops [9];
   logic [31:0] rnd;

   initial begin
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; mem_ready = 1'b0;
      take_branch = 1'b0; instr = 32'd0;
      repeat (2) @(negedge clk);
      check_quiet("reset", 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_quiet("idle_no_start", 1'b0, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);  // add x3,x1,x2
      run_instr(32'h402081B3, 0, 0, 1'b0, 1'b0);  // sub
      run_instr(32'h4010D213, 0, 0, 1'b0, 1'b0);  // srai x4,x1,1
      run_instr(32'h00508013, 0, 0, 1'b0, 1'b0);  // addi x0,x1,5
      run_instr(32'h0000A283, 3, 3, 1'b0, 1'b0);  // lw x5,0(x1)
      run_instr(32'h00208463, 0, 0, 1'b0, 1'b0);  // beq not taken
      run_instr(32'h00208463, 0, 0, 1'b1, 1'b1);  // beq taken, then stop

      for (int n = 0; n < 80; n++) begin
         rnd       = $urandom;
         rnd[6:0]  = ops[$urandom_range(0, 8)];
         if ($urandom_range(0, 5) == 0) rnd[11:7] = 5'd0;
         run_instr(rnd, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), $urandom_range(0, 7) == 0);
      end

      run_instr(32'h00000000, 1, 0, 1'b0, 1'b0);
      start = 1'b1; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_quiet("trap_hold", 1'b1, 1'b0);
      rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
      #1;
      check_quiet("reset_clears_illegal", 1'b0, 1'b0);

      @(negedge clk);
      rst_n = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #1;
         check("fetch_waiting", 32'({busy, mem_req, timeout}), 32'(3'b110));
         @(negedge clk);
      end
      #1;
      check_quiet("timeout_trap", 1'b0, 1'b1);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; mem_ready = 1'b1; instr = 32'h0000A283;
      #1;
      check("rst_test_ir_wr", 32'(ir_wr), 32'd1);
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("mem_before_rst", 32'({mem_req, mem_addr_sel, busy}), 32'(3'b111));
      rst_n = 1'b0;
      #1;
      check_quiet("rst_mid_mem", 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check_quiet("post_rst_idle", 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the register file's reg_rd/reg_wr strobes, memory handshake, PC update and ALU/mux selects. It decodes from the datapath instruction register (IR) and uses a datapath-side registered ALU result (ALUOut).

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req may stay high without mem_ready before trapping.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  leave IDLE and begin fetching.
stop  in  1  return to IDLE at the next instruction boundary.
instr  in  32  IR contents, stable from DECODE onward.
mem_ready  in  1  memory completion, valid only while mem_req=1.
take_branch  in  1  ALU compare result, valid in EXEC.
ir_wr  out  1  load IR from memory read data.
pc_wr  out  1  update PC.
pc_src  out  2  0 PC+4, 1 PC+imm, 2 ALUOut&~1.
reg_rd  out  1  register file read enable.
reg_wr  out  1  register file write enable.
wb_sel  out  2  0 ALUOut, 1 mem data, 2 PC+4.
alu_src_a  out  2  0 rs1, 1 PC, 2 zero.
alu_src_b  out  2  0 rs2, 1 imm, 2 constant 4.
alu_op  out  4  ALU function code.
imm_sel  out  3  0 I, 1 S, 2 B, 3 U, 4 J.
mem_req  out  1  memory request.
mem_we  out  1  store when 1.
mem_addr_sel  out  1  0 PC, 1 ALUOut.
busy  out  1  high in every state except IDLE and TRAP.
illegal  out  1  sticky: unsupported opcode.
timeout  out  1  sticky: memory timeout.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are decoded from the state register and instr. No output may be combinationally dependent on mem_ready except ir_wr and pc_wr.
- Reset (async, any state): state goes to IDLE and every output is 0 immediately. A memory transaction in flight is abandoned.
- IDLE: all outputs 0. start=1 moves to FETCH.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. Hold until mem_ready. In the mem_ready cycle assert ir_wr=1 and move to DECODE.
- DECODE: reg_rd=1; the register file samples operands on the next rising edge.
  - Supported opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
  - Any other opcode moves to TRAP and sets illegal=1. Otherwise move to EXEC.
- EXEC, by opcode:
  - R: a=rs1, b=rs2, alu_op={f7[5],f3}.
  - I-ALU: a=rs1, b=imm, alu_op={f3==101 ? f7[5] : 0, f3}.
  - LOAD/STORE/JALR: ADD (0000), a=rs1, b=imm.
  - LUI: a=zero, b=imm, U-imm. AUIPC: a=PC, b=imm.
  - JAL: a=PC, b=4.
  - BRANCH: alu_op={1,f3}, a=rs1, b=rs2, B-imm; pc_wr=1 with pc_src = take_branch ? 1 : 0. This is an instruction boundary.
  - Next state: LOAD/STORE to MEM; all others to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 only for STORE. Hold until mem_ready.
  - STORE: pc_wr=1, pc_src=0 in the mem_ready cycle; this is a boundary.
  - LOAD: move to WB.
- WB: reg_wr=1 for the entire cycle, except that it is forced to 0 when instr[11:7]==0 (the register file does not protect x0).
  - wb_sel: LOAD=1, JAL/JALR=2, else 0.
  - pc_wr=1 with pc_src: JAL=1, JALR=2, else 0. WB is a boundary.
- Boundary rule: move to IDLE if stop=1, else to FETCH.
- Timeout: a wait counter clears on entry to FETCH/MEM and increments while mem_req=1 and mem_ready=0. When it reaches TIMEOUT_CYCLES, move to TRAP and set timeout=1.
- TRAP: all control outputs 0, illegal/timeout held. Exit only via rst_n.
- Latency with zero-wait memory, from FETCH entry to next FETCH entry: R/I/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH 3.

Decomposition:
- Package rv_ctrl_pkg: opcode constants, state enum, pc_src/wb_sel/alu_src/imm_sel encodings, alu_op codes.
- Sub-module rv_ctrl_decode: combinational opcode/funct decode into a control bundle plus an illegal flag. The FSM and timeout counter stay in the top.

Test Plan:
- Preload R1=7, R2=0xA; start; run add x3,x1,x2 (0x002081B3) with mem_ready tied 1 -> FETCH..WB in 4 cycles, alu_op=0000, reg_wr=1 in WB, wb_sel=0, pc_src=0.
- Run sub (0x402081B3) -> alu_op=1000. Run srai x4,x1,1 (0x4010D213) -> alu_op=1101.
- Run addi x0,x1,5 (0x00508013) -> reg_wr stays 0 throughout WB; pc_wr=1.
- Run lw x5,0(x1) with mem_ready delayed 3 cycles in FETCH and in MEM -> 11 cycles total; wb_sel=1 in WB.
- Run beq x1,x2 (0x00208463) with take_branch=0 and then 1 -> pc_src=0 and 1 respectively; 3 cycles each; reg_wr never asserted.
- Run instr=0x00000000 -> TRAP, illegal=1, busy=0. Fresh run with mem_ready=0 -> timeout=1 after 16 cycles. Assert rst_n=0 mid-MEM -> all outputs 0 at once, state IDLE.
